// File: rtl/core_mc.sv
// core_mc: multi-cycle accumulator core with a call stack and IO port.
// Instruction word is {opcode[3:0], operand[NBOPER-1:0]}.
module core_mc #(
  parameter int NUBITS = 32,
  parameter int NBOPER = 9,
  parameter int MDATAW = 9,
  parameter int MINSTW = 9,
  parameter int SDEPTH = 8,
  parameter int NUIO   = 8,
  localparam int NBINST = 4 + NBOPER,
  localparam int IOW    = $clog2(NUIO)
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     instr_req,
  output logic [MINSTW-1:0]        instr_addr,
  input  logic [NBINST-1:0]        instr,
  input  logic                     instr_ack,
  output logic                     mem_req,
  output logic                     mem_wr,
  output logic [MDATAW-1:0]        mem_addr,
  output logic [NUBITS-1:0]        mem_wdata,
  input  logic [NUBITS-1:0]        mem_rdata,
  input  logic                     mem_ack,
  input  logic [NUBITS-1:0]        io_in,
  output logic [IOW-1:0]           io_addr,
  output logic                     io_rd,
  output logic                     io_wr,
  output logic [NUBITS-1:0]        io_out,
  output logic signed [NUBITS-1:0] acc,
  output logic                     halted,
  output logic                     fault
);

  localparam int SHW = $clog2(NUBITS);
  localparam int SPW = $clog2(SDEPTH + 1);
  localparam int STW = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_SHL  = 4'h9;
  localparam logic [3:0] OP_SHR  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_JZ   = 4'hC;
  localparam logic [3:0] OP_CALL = 4'hD;
  localparam logic [3:0] OP_RET  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    FETCH, EXEC, MEM, HALT, FAULT
  } state_t;

  state_t              state;
  logic [NBINST-1:0]   ir;
  logic [MINSTW-1:0]   pc;
  logic [SPW-1:0]      sp;
  logic [MINSTW-1:0]   stack [SDEPTH];

  logic [3:0]          op;
  logic [NBOPER-1:0]   opr;
  logic [3:0]          f_op;
  logic [NBOPER-1:0]   f_opr;
  logic                f_io;
  logic [MINSTW-1:0]   pc_inc;
  logic [MINSTW-1:0]   tgt;
  logic [SHW-1:0]      sh;
  logic [NUBITS-1:0]   imm;
  logic [NUBITS-1:0]   mem_res;
  logic                st_full;
  logic                st_empty;
  logic                push_en;
  logic [STW-1:0]      top_idx;
  logic [STW-1:0]      push_idx;

  assign op       = ir[NBINST-1:NBOPER];
  assign opr      = ir[NBOPER-1:0];
  assign f_op     = instr[NBINST-1:NBOPER];
  assign f_opr    = instr[NBOPER-1:0];
  assign f_io     = (f_op == OP_NOP) && f_opr[NBOPER-1];
  assign pc_inc   = pc + 1'b1;
  assign tgt      = opr[MINSTW-1:0];
  assign sh       = opr[SHW-1:0];
  assign imm      = {{(NUBITS-NBOPER){opr[NBOPER-1]}}, opr};
  assign st_full  = (sp == SPW'(SDEPTH));
  assign st_empty = (sp == '0);
  assign top_idx  = STW'(sp - 1'b1);
  assign push_idx = STW'(sp);
  assign push_en  = (state == EXEC) && (op == OP_CALL) && !st_full;

  assign instr_addr = pc;

  always_comb begin
    mem_res = acc;
    unique case (op)
      OP_LD:   mem_res = mem_rdata;
      OP_ADD:  mem_res = acc + mem_rdata;
      OP_SUB:  mem_res = acc - mem_rdata;
      OP_AND:  mem_res = acc & mem_rdata;
      OP_OR:   mem_res = acc | mem_rdata;
      OP_XOR:  mem_res = acc ^ mem_rdata;
      default: mem_res = acc;
    endcase
  end

  // Stack storage needs no reset: only entries below sp are ever read.
  always_ff @(posedge clk) begin
    if (push_en) stack[push_idx] <= pc_inc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FETCH;
      ir        <= '0;
      pc        <= '0;
      acc       <= '0;
      sp        <= '0;
      instr_req <= 1'b1;
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      io_addr   <= '0;
      io_rd     <= 1'b0;
      io_wr     <= 1'b0;
      io_out    <= '0;
      halted    <= 1'b0;
      fault     <= 1'b0;
    end else begin
      io_rd <= 1'b0;
      io_wr <= 1'b0;
      unique case (state)
        FETCH: begin
          if (instr_req && instr_ack) begin
            ir        <= instr;
            instr_req <= 1'b0;
            state     <= EXEC;
            io_addr   <= f_opr[IOW-1:0];
            if (f_io) begin
              io_rd <= !f_opr[NBOPER-2];
              io_wr <= f_opr[NBOPER-2];
              if (f_opr[NBOPER-2]) io_out <= acc;
            end
          end
        end
        EXEC: begin
          state     <= FETCH;
          instr_req <= 1'b1;
          pc        <= pc_inc;
          unique case (op)
            OP_NOP: begin
              if (opr[NBOPER-1] && !opr[NBOPER-2]) acc <= io_in;
            end
            OP_LDI: acc <= imm;
            OP_LD, OP_ST, OP_ADD, OP_SUB,
            OP_AND, OP_OR, OP_XOR: begin
              state     <= MEM;
              instr_req <= 1'b0;
              pc        <= pc;
              mem_req   <= 1'b1;
              mem_wr    <= (op == OP_ST);
              mem_addr  <= opr[MDATAW-1:0];
              mem_wdata <= acc;
            end
            OP_SHL: acc <= acc << sh;
            OP_SHR: acc <= acc >>> sh;
            OP_JMP: pc  <= tgt;
            OP_JZ:  pc  <= (acc == '0) ? tgt : pc_inc;
            OP_CALL: begin
              if (st_full) begin
                state     <= FAULT;
                instr_req <= 1'b0;
                pc        <= pc;
                fault     <= 1'b1;
              end else begin
                sp <= sp + 1'b1;
                pc <= tgt;
              end
            end
            OP_RET: begin
              if (st_empty) begin
                state     <= FAULT;
                instr_req <= 1'b0;
                pc        <= pc;
                fault     <= 1'b1;
              end else begin
                sp <= sp - 1'b1;
                pc <= stack[top_idx];
              end
            end
            OP_HALT: begin
              state     <= HALT;
              instr_req <= 1'b0;
              pc        <= pc;
              halted    <= 1'b1;
            end
          endcase
        end
        MEM: begin
          if (mem_req && mem_ack) begin
            acc       <= mem_res;
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            pc        <= pc_inc;
            instr_req <= 1'b1;
            state     <= FETCH;
          end
        end
        HALT:  state <= HALT;
        FAULT: state <= FAULT;
        default: state <= FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_core_mc.sv
// Bench for core_mc: ROM/RAM/IO responders, IO scoreboard, ALU vector
// table and hand-written sequences for stack, reset and wait states.
module tb_core_mc;

  localparam int NUBITS = 32;
  localparam int NBOPER = 9;
  localparam int NBINST = 13;
  localparam int MDATAW = 9;
  localparam int MINSTW = 9;
  localparam int SDEPTH = 2;
  localparam int NUIO   = 8;
  localparam int IOW    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                     instr_req;
  logic [MINSTW-1:0]        instr_addr;
  logic [NBINST-1:0]        instr;
  logic                     instr_ack;
  logic                     mem_req;
  logic                     mem_wr;
  logic [MDATAW-1:0]        mem_addr;
  logic [NUBITS-1:0]        mem_wdata;
  logic [NUBITS-1:0]        mem_rdata;
  logic                     mem_ack;
  logic [NUBITS-1:0]        io_in = '0;
  logic [IOW-1:0]           io_addr;
  logic                     io_rd;
  logic                     io_wr;
  logic [NUBITS-1:0]        io_out;
  logic signed [NUBITS-1:0] acc;
  logic                     halted;
  logic                     fault;

  core_mc #(
    .NUBITS(NUBITS), .NBOPER(NBOPER), .MDATAW(MDATAW),
    .MINSTW(MINSTW), .SDEPTH(SDEPTH), .NUIO(NUIO)
  ) dut (
    .clk(clk), .rst(rst),
    .instr_req(instr_req), .instr_addr(instr_addr),
    .instr(instr), .instr_ack(instr_ack),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .io_in(io_in), .io_addr(io_addr), .io_rd(io_rd), .io_wr(io_wr),
    .io_out(io_out), .acc(acc), .halted(halted), .fault(fault)
  );

  logic [NBINST-1:0] rom  [512];
  logic [NUBITS-1:0] dmem [512];
  int mem_delay = 0;
  int mwait = 0;
  logic [MDATAW-1:0] st_addr = '0;
  logic [NUBITS-1:0] st_data = '0;

  assign instr     = rom[instr_addr];
  assign instr_ack = instr_req;
  assign mem_rdata = dmem[mem_addr];
  assign mem_ack   = mem_req && (mwait >= mem_delay);

  always @(posedge clk) begin
    if (!rst && mem_req && mem_ack && mem_wr) begin
      st_addr <= mem_addr;
      st_data <= mem_wdata;
    end
    if (rst || !mem_req || mem_ack) mwait <= 0;
    else mwait <= mwait + 1;
  end

  typedef struct {
    logic [IOW-1:0]    addr;
    logic [NUBITS-1:0] data;
  } io_exp_t;
  io_exp_t exp_q[$];

  typedef struct {
    logic [3:0]        op;
    logic [8:0]        opr;
    logic [NUBITS-1:0] a;
    logic [NUBITS-1:0] m;
    logic [NUBITS-1:0] exp;
  } vec_t;
  vec_t vt[16];

  int n_vec = 0;
  int n_bad = 0;
  int mem_max = 0;
  int mem_unst = 0;

  localparam logic [12:0] HLT = 13'h1E00;
  localparam logic [12:0] OUT0 = 13'h0180;

  function automatic logic [12:0] ins(input logic [3:0] o,
                                      input logic [8:0] a);
    return {o, a};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic hold();
    @(negedge clk);
    rst = 1'b1;
    mem_delay = 0;
    exp_q.delete();
    for (int i = 0; i < 512; i++) rom[i] = HLT;
  endtask

  task automatic go();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run(input string nm, input int limit,
                     output int cyc);
    io_exp_t e;
    int mrun;
    logic [MDATAW-1:0] pa;
    cyc = 0;
    mrun = 0;
    pa = '0;
    mem_max = 0;
    mem_unst = 0;
    while (!(halted || fault) && cyc < limit) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (io_wr) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL %s extra io_wr: io_out %h", nm, io_out);
        end else begin
          e = exp_q.pop_front();
          chk({nm, " io_out"}, io_out, e.data);
          chk({nm, " io_addr"}, 32'(io_addr), 32'(e.addr));
        end
      end
      if (mem_req) begin
        if (mrun > 0 && mem_addr != pa) mem_unst++;
        mrun++;
        pa = mem_addr;
        if (mrun > mem_max) mem_max = mrun;
      end else begin
        mrun = 0;
      end
    end
    if (cyc >= limit) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s timeout: got %0d cycles want <%0d", nm, cyc,
               limit);
    end
    chk({nm, " pending outs"}, exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int w;
    logic busy;

    vt[0]  = '{4'h4, 9'd1, 32'h7FFFFFFF, 32'h1, 32'h80000000};
    vt[1]  = '{4'h4, 9'd1, 32'hFFFFFFFF, 32'h1, 32'h00000000};
    vt[2]  = '{4'h5, 9'd1, 32'h0, 32'h1, 32'hFFFFFFFF};
    vt[3]  = '{4'h6, 9'd1, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0};
    vt[4]  = '{4'h7, 9'd1, 32'hF0000000, 32'h0000000F, 32'hF000000F};
    vt[5]  = '{4'h8, 9'd1, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555};
    vt[6]  = '{4'h2, 9'd1, 32'h123, 32'hCAFEBABE, 32'hCAFEBABE};
    vt[7]  = '{4'h1, 9'h0FF, 32'h777, 32'h0, 32'h000000FF};
    vt[8]  = '{4'h1, 9'h100, 32'h777, 32'h0, 32'hFFFFFF00};
    vt[9]  = '{4'h9, 9'd4, 32'h12345678, 32'h0, 32'h23456780};
    vt[10] = '{4'hA, 9'd4, 32'h80000000, 32'h0, 32'hF8000000};
    vt[11] = '{4'hA, 9'h023, 32'h40000000, 32'h0, 32'h08000000};
    vt[12] = '{4'h9, 9'd0, 32'h1, 32'h0, 32'h1};
    vt[13] = '{4'h0, 9'h105, 32'h5, 32'hDEADBEEF, 32'hDEADBEEF};
    vt[14] = '{4'h0, 9'h000, 32'h42, 32'h99, 32'h42};
    vt[15] = '{4'h3, 9'd1, 32'h77, 32'h0, 32'h77};

    for (int i = 0; i < 512; i++) begin
      rom[i] = HLT;
      dmem[i] = '0;
    end

    // reset state
    repeat (2) @(negedge clk);
    chk("rst instr_req", instr_req, 1);
    chk("rst instr_addr", instr_addr, 0);
    chk("rst mem_req", mem_req, 0);
    chk("rst mem_wr", mem_wr, 0);
    chk("rst io_rd", io_rd, 0);
    chk("rst io_wr", io_wr, 0);
    chk("rst io_out", io_out, 0);
    chk("rst acc", acc, 0);
    chk("rst halted", halted, 0);
    chk("rst fault", fault, 0);

    // LDI -3; OUT 2; HALT
    hold();
    rom[0] = ins(4'h1, 9'h1FD);
    rom[1] = ins(4'h0, 9'h182);
    exp_q.push_back('{3'd2, 32'hFFFFFFFD});
    go();
    run("ldi_out", 200, cyc);
    chk("ldi_out cycles", cyc, 6);
    chk("ldi_out halted", halted, 1);

    // ALU/IO vector table
    foreach (vt[i]) begin
      hold();
      rom[0] = ins(4'h2, 9'd0);
      rom[1] = ins(vt[i].op, vt[i].opr);
      rom[2] = OUT0;
      dmem[0] = vt[i].a;
      dmem[1] = vt[i].m;
      io_in = vt[i].m;
      exp_q.push_back('{3'd0, vt[i].exp});
      go();
      run($sformatf("vec%0d", i), 200, cyc);
      chk($sformatf("vec%0d halted", i), halted, 1);
    end
    chk("st addr", 32'(st_addr), 32'd1);
    chk("st data", st_data, 32'h77);

    // LD/SUB/JZ with 3-cycle memory wait
    hold();
    rom[0] = ins(4'h2, 9'd5);
    rom[1] = ins(4'h5, 9'd6);
    rom[2] = ins(4'hC, 9'h040);
    rom[3] = OUT0;
    dmem[5] = 32'd10;
    dmem[6] = 32'd15;
    mem_delay = 3;
    exp_q.push_back('{3'd0, 32'hFFFFFFFB});
    go();
    run("memwait", 400, cyc);
    chk("memwait acc", acc, 32'hFFFFFFFB);
    chk("memwait pc", instr_addr, 4);
    chk("memwait req len", mem_max, 4);
    chk("memwait addr stable", mem_unst, 0);
    chk("memwait halted", halted, 1);

    // stack overflow at depth 2
    hold();
    rom[0] = ins(4'hD, 9'h010);
    rom[9'h10] = ins(4'hD, 9'h020);
    rom[9'h20] = ins(4'hD, 9'h030);
    go();
    run("ovf", 200, cyc);
    chk("ovf fault", fault, 1);
    chk("ovf halted", halted, 0);
    chk("ovf pc", instr_addr, 9'h020);
    busy = 1'b0;
    repeat (5) begin
      @(negedge clk);
      busy = busy | instr_req | mem_req | io_rd | io_wr;
    end
    chk("ovf quiet", busy, 0);

    // RET on empty stack
    hold();
    rom[0] = ins(4'hE, 9'd0);
    go();
    run("unf", 200, cyc);
    chk("unf fault", fault, 1);
    chk("unf pc", instr_addr, 0);

    // CALL then RET returns to caller+1
    hold();
    rom[0] = ins(4'h1, 9'd7);
    rom[1] = ins(4'hD, 9'h010);
    rom[2] = OUT0;
    rom[9'h10] = ins(4'hE, 9'd0);
    exp_q.push_back('{3'd0, 32'd7});
    go();
    run("callret", 200, cyc);
    chk("callret pc", instr_addr, 3);
    chk("callret fault", fault, 0);

    // JZ taken, JMP
    hold();
    rom[0] = ins(4'h1, 9'd0);
    rom[1] = ins(4'hC, 9'h020);
    rom[9'h20] = ins(4'h1, 9'd9);
    rom[9'h21] = ins(4'hB, 9'h030);
    rom[9'h30] = OUT0;
    exp_q.push_back('{3'd0, 32'd9});
    go();
    run("jmp", 200, cyc);
    chk("jmp pc", instr_addr, 9'h031);

    // pc wraps from 0x1FF to 0
    hold();
    rom[0] = ins(4'hC, 9'h1FF);
    rom[9'h1FF] = ins(4'h1, 9'd4);
    rom[1] = OUT0;
    exp_q.push_back('{3'd0, 32'd4});
    go();
    run("wrap", 200, cyc);
    chk("wrap pc", instr_addr, 2);

    // shifts, then halt quiet
    hold();
    rom[0] = ins(4'h1, 9'd1);
    rom[1] = ins(4'h9, 9'd31);
    rom[2] = OUT0;
    rom[3] = ins(4'hA, 9'd31);
    rom[4] = ins(4'h0, 9'h181);
    exp_q.push_back('{3'd0, 32'h80000000});
    exp_q.push_back('{3'd1, 32'hFFFFFFFF});
    go();
    run("shift", 200, cyc);
    chk("shift halted", halted, 1);
    chk("shift fault", fault, 0);
    busy = 1'b0;
    repeat (5) begin
      @(negedge clk);
      busy = busy | instr_req | mem_req | io_rd | io_wr;
    end
    chk("halt quiet", busy, 0);

    // reset while waiting in MEM
    hold();
    rom[0] = ins(4'h1, 9'd5);
    rom[1] = ins(4'h2, 9'd3);
    rom[2] = OUT0;
    dmem[3] = 32'h1234;
    mem_delay = 50;
    go();
    w = 0;
    while (!mem_req && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("mrst mem_req seen", mem_req, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst mem_req", mem_req, 0);
    chk("mrst acc", acc, 0);
    chk("mrst pc", instr_addr, 0);
    chk("mrst instr_req", instr_req, 1);
    @(negedge clk);
    mem_delay = 0;
    exp_q.push_back('{3'd0, 32'h1234});
    rst = 1'b0;
    run("mrst", 200, cyc);
    chk("mrst halted", halted, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
